// File: rtl/radar_samp_packer.sv
// Packs 32-bit sc16 receive samples into 512-bit AXI-stream words for the DDR3 sample buffer.
// A frame end flushes any partial word with a trimmed tkeep; one instance serves one channel.
`timescale 1ns/1ps
module radar_samp_packer #(
    parameter int unsigned SAMP_AXI_DATA_WIDTH  = 512,
    parameter int unsigned SAMP_AXI_TID_WIDTH   = 1,
    parameter int unsigned SAMP_AXI_TDEST_WIDTH = 1,
    parameter int unsigned SAMP_AXI_TUSER_WIDTH = 1,
    parameter int unsigned TID_VALUE            = 0,
    parameter int unsigned TDEST_VALUE          = 0
) (
    input  logic                              ce_clk,
    input  logic                              ce_rst_n,
    input  logic                              clear,
    input  logic [31:0]                       s_axis_tdata,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [SAMP_AXI_DATA_WIDTH-1:0]    samp_axis_tdata,
    output logic                              samp_axis_tvalid,
    output logic                              samp_axis_tlast,
    output logic [SAMP_AXI_DATA_WIDTH/8-1:0]  samp_axis_tkeep,
    output logic [SAMP_AXI_DATA_WIDTH/8-1:0]  samp_axis_tstrb,
    output logic [SAMP_AXI_TID_WIDTH-1:0]     samp_axis_tid,
    output logic [SAMP_AXI_TDEST_WIDTH-1:0]   samp_axis_tdest,
    output logic [SAMP_AXI_TUSER_WIDTH-1:0]   samp_axis_tuser,
    input  logic                              samp_axis_tready,
    output logic [31:0]                       frame_cnt
);

    localparam int unsigned LANE_W         = 32;
    localparam int unsigned LANES          = 16;
    localparam int unsigned DATA_W         = LANE_W * LANES;
    localparam int unsigned KEEP_W         = DATA_W / 8;
    localparam int unsigned BYTES_PER_LANE = LANE_W / 8;
    localparam int unsigned CNT_W          = 4;

    generate
        if (SAMP_AXI_DATA_WIDTH != DATA_W) begin : g_bad_width
            $error("radar_samp_packer: SAMP_AXI_DATA_WIDTH must be 512");
        end
    endgenerate

    logic [DATA_W-1:0] acc_q, acc_d, merged_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sof_q, sof_d;
    logic              rst_q;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [KEEP_W-1:0] out_keep_q, out_keep_d, keep_c;
    logic              out_last_q, out_last_d;
    logic              out_sof_q, out_sof_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic              accept_c, complete_c, drain_c;

    // Ready depends only on the output register, so the path stays short on every beat.
    assign s_axis_tready = rst_q && !clear && (!out_valid_q || samp_axis_tready);
    assign accept_c      = s_axis_tvalid && s_axis_tready;
    assign complete_c    = accept_c && ((cnt_q == CNT_W'(LANES - 1)) || s_axis_tlast);
    assign drain_c       = out_valid_q && samp_axis_tready;

    // Accumulator with the incoming sample merged at lane cnt; lanes above cnt are zero.
    always_comb begin
        merged_c = acc_q;
        keep_c   = '0;
        merged_c[LANE_W*cnt_q +: LANE_W] = s_axis_tdata;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i > 32'(cnt_q)) begin
                merged_c[LANE_W*i +: LANE_W] = '0;
            end
        end
        for (int unsigned b = 0; b < KEEP_W; b++) begin
            keep_c[b] = (b / BYTES_PER_LANE) <= 32'(cnt_q);
        end
    end

    // Next-state: fill, flush on word completion, drain of the output register, abort.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sof_d       = sof_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_sof_d   = out_sof_q;
        out_valid_d = out_valid_q;
        frame_cnt_d = frame_cnt_q;

        if (drain_c) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                frame_cnt_d = frame_cnt_q + 32'd1;
            end
        end

        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            sof_d = 1'b1;
        end else if (complete_c) begin
            out_data_d  = merged_c;
            out_keep_d  = keep_c;
            out_last_d  = s_axis_tlast;
            out_sof_d   = sof_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sof_d       = s_axis_tlast;
        end else if (accept_c) begin
            acc_d = merged_c;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Ready enable: held low in reset and for the first cycle after release.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            rst_q <= 1'b0;
        end else begin
            rst_q <= 1'b1;
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sof_q       <= 1'b1;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_sof_q   <= 1'b0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sof_q       <= sof_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_sof_q   <= out_sof_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign samp_axis_tdata  = out_data_q;
    assign samp_axis_tvalid = out_valid_q;
    assign samp_axis_tlast  = out_last_q;
    assign samp_axis_tkeep  = out_keep_q;
    assign samp_axis_tstrb  = out_keep_q;
    assign samp_axis_tid    = SAMP_AXI_TID_WIDTH'(TID_VALUE);
    assign samp_axis_tdest  = SAMP_AXI_TDEST_WIDTH'(TDEST_VALUE);
    assign samp_axis_tuser  = SAMP_AXI_TUSER_WIDTH'(out_sof_q);
    assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_radar_samp_packer.sv
// Bench for radar_samp_packer: directed and random frames checked against a frame-chunking
// reference model; a negedge monitor scores every output word and hold-stability.
`timescale 1ns/1ps
module tb_radar_samp_packer;

    logic         ce_clk = 1'b0;
    logic         ce_rst_n = 1'b0;
    logic         clear = 1'b0;
    logic [31:0]  s_tdata = '0;
    logic         s_tlast = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [511:0] o_tdata;
    logic         o_tvalid, o_tlast;
    logic [63:0]  o_tkeep, o_tstrb;
    logic [0:0]   o_tid, o_tdest, o_tuser;
    logic         o_tready = 1'b1;
    logic [31:0]  frame_cnt;

    radar_samp_packer dut (
        .ce_clk(ce_clk), .ce_rst_n(ce_rst_n), .clear(clear),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .samp_axis_tdata(o_tdata), .samp_axis_tvalid(o_tvalid), .samp_axis_tlast(o_tlast),
        .samp_axis_tkeep(o_tkeep), .samp_axis_tstrb(o_tstrb), .samp_axis_tid(o_tid),
        .samp_axis_tdest(o_tdest), .samp_axis_tuser(o_tuser), .samp_axis_tready(o_tready),
        .frame_cnt(frame_cnt)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic         sof;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] pend[$];
    logic        sof_m = 1'b1;
    int          exp_frames = 0;
    int          tests = 0;
    int          fails = 0;
    int          stalls = 0;
    logic        fixed_rdy = 1'b1;
    logic        rand_rdy = 1'b0;
    logic        held = 1'b0;
    word_t       mon_w;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: samples collect into a word of up to 16 lanes; a full word or frame end emits it.
    task automatic model_push(input logic [31:0] d, input logic last);
        word_t w;
        int n;
        pend.push_back(d);
        n = pend.size();
        if (n == 16 || last) begin
            w.data = '0;
            for (int i = 0; i < n; i++) w.data[i*32 +: 32] = pend[i];
            w.keep = (n == 16) ? {64{1'b1}} : ((64'd1 << (4 * n)) - 64'd1);
            w.last = last;
            w.sof  = sof_m;
            sof_m  = last;
            exp_q.push_back(w);
            pend.delete();
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int waited = 0;
        logic ok = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        while (waited < 500) begin
            @(negedge ce_clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        stalls += waited;
        check("beat_accepted", 512'(ok), 512'(1));
        if (ok) model_push(d, last);
        @(posedge ce_clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input logic rnd);
        for (int k = 0; k < n; k++) begin
            send_beat(rnd ? 32'($urandom) : base + 32'(k), k == n - 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge ce_clk);
        end
        check("drain_empty", 512'(exp_q.size()), 512'(0));
        @(posedge ce_clk);
        #1;
    endtask

    // Downstream ready: fixed level or random per cycle.
    always @(posedge ce_clk) begin
        #1;
        o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    end

    // Output monitor: hold stability and scoreboard on every handshake.
    always @(negedge ce_clk) begin
        if (!ce_rst_n) begin
            held = 1'b0;
        end else begin
            if (held) check("hold_valid", 512'(o_tvalid), 512'(1));
            if (o_tvalid && !o_tready && exp_q.size() > 0) begin
                check("hold_data", o_tdata, exp_q[0].data);
                check("hold_keep", 512'(o_tkeep), 512'(exp_q[0].keep));
            end
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 512'(o_tvalid), 512'(0));
                end else begin
                    mon_w = exp_q.pop_front();
                    check("word_data", o_tdata, mon_w.data);
                    check("word_keep", 512'(o_tkeep), 512'(mon_w.keep));
                    check("word_strb", 512'(o_tstrb), 512'(mon_w.keep));
                    check("word_last", 512'(o_tlast), 512'(mon_w.last));
                    check("word_tuser", 512'(o_tuser), 512'(mon_w.sof));
                    check("word_tid", 512'(o_tid), 512'(0));
                    check("word_tdest", 512'(o_tdest), 512'(0));
                    check("word_frame_cnt", 512'(frame_cnt), 512'(exp_frames));
                    if (mon_w.last) exp_frames++;
                end
            end
            held = o_tvalid && !o_tready;
        end
    end

    initial begin
        // Reset values
        repeat (3) @(posedge ce_clk);
        #1;
        check("rst_tvalid", 512'(o_tvalid), 512'(0));
        check("rst_tdata", o_tdata, 512'(0));
        check("rst_tkeep", 512'(o_tkeep), 512'(0));
        check("rst_tstrb", 512'(o_tstrb), 512'(0));
        check("rst_tlast", 512'(o_tlast), 512'(0));
        check("rst_tuser", 512'(o_tuser), 512'(0));
        check("rst_sready", 512'(s_tready), 512'(0));
        check("rst_frame_cnt", 512'(frame_cnt), 512'(0));
        @(negedge ce_clk);
        ce_rst_n = 1'b1;
        #1;
        check("rel_sready_0", 512'(s_tready), 512'(0));
        @(negedge ce_clk);
        check("rel_sready_1", 512'(s_tready), 512'(1));
        @(posedge ce_clk);
        #1;

        // Full word, valid one cycle after the completing beat
        for (int k = 0; k < 16; k++) send_beat(32'(k), k == 15);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("latency_valid", 512'(o_tvalid), 512'(1));
        wait_drain();
        check("full_frame_cnt", 512'(frame_cnt), 512'(1));

        // Partial flush of a 20-sample frame
        send_frame(20, 32'hA000_0000, 1'b0);
        wait_drain();
        check("partial_frame_cnt", 512'(frame_cnt), 512'(2));

        // Backpressure: downstream stalled 40 cycles during a 48-sample frame
        fixed_rdy = 1'b0;
        @(posedge ce_clk);
        #1;
        fork
            begin
                repeat (40) @(posedge ce_clk);
                fixed_rdy = 1'b1;
            end
        join_none
        for (int k = 0; k < 16; k++) send_beat(32'hB000_0000 + 32'(k), 1'b0);
        s_tvalid = 1'b0;
        @(negedge ce_clk);
        check("bp_sready_low", 512'(s_tready), 512'(0));
        check("bp_tvalid_high", 512'(o_tvalid), 512'(1));
        @(posedge ce_clk);
        #1;
        for (int k = 16; k < 48; k++) send_beat(32'hB000_0000 + 32'(k), k == 47);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        wait_drain();
        check("bp_frame_cnt", 512'(frame_cnt), 512'(3));

        // Clear after 7 samples; the beat offered alongside clear is refused
        for (int k = 0; k < 7; k++) send_beat(32'hC000_0000 + 32'(k), 1'b0);
        s_tdata  = 32'hDEAD_BEEF;
        s_tvalid = 1'b1;
        clear    = 1'b1;
        @(negedge ce_clk);
        check("clear_sready", 512'(s_tready), 512'(0));
        @(posedge ce_clk);
        #1;
        clear    = 1'b0;
        s_tvalid = 1'b0;
        pend.delete();
        sof_m = 1'b1;
        check("clear_no_word", 512'(o_tvalid), 512'(0));
        send_frame(16, 32'hD000_0000, 1'b0);
        wait_drain();
        check("clear_frame_cnt", 512'(frame_cnt), 512'(4));

        // Back-to-back 160-sample frame with no input bubble
        stalls = 0;
        send_frame(160, 32'hE000_0000, 1'b0);
        check("b2b_no_stall", 512'(stalls), 512'(0));
        wait_drain();
        check("b2b_frame_cnt", 512'(frame_cnt), 512'(5));

        // Random frames under random downstream ready
        rand_rdy = 1'b1;
        for (int f = 0; f < 8; f++) send_frame($urandom_range(1, 40), 32'h0, 1'b1);
        rand_rdy  = 1'b0;
        fixed_rdy = 1'b1;
        wait_drain();
        check("rand_frame_cnt", 512'(frame_cnt), 512'(13));

        // Async reset mid-cycle while a word is held
        fixed_rdy = 1'b0;
        @(posedge ce_clk);
        #1;
        send_frame(16, 32'hF000_0000, 1'b0);
        repeat (2) @(posedge ce_clk);
        #3;
        ce_rst_n = 1'b0;
        #1;
        check("arst_tvalid", 512'(o_tvalid), 512'(0));
        check("arst_tdata", o_tdata, 512'(0));
        check("arst_tkeep", 512'(o_tkeep), 512'(0));
        check("arst_tlast", 512'(o_tlast), 512'(0));
        check("arst_tuser", 512'(o_tuser), 512'(0));
        check("arst_sready", 512'(s_tready), 512'(0));
        check("arst_frame_cnt", 512'(frame_cnt), 512'(0));
        exp_q.delete();
        pend.delete();
        sof_m = 1'b1;
        exp_frames = 0;
        @(negedge ce_clk);
        #1;
        ce_rst_n  = 1'b1;
        fixed_rdy = 1'b1;
        #1;
        check("arst_rel_sready_0", 512'(s_tready), 512'(0));
        @(negedge ce_clk);
        check("arst_rel_sready_1", 512'(s_tready), 512'(1));
        @(posedge ce_clk);
        #1;
        send_frame(5, 32'h5000_0000, 1'b0);
        wait_drain();
        check("post_rst_frame_cnt", 512'(frame_cnt), 512'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/radar_samp_packer.md
# radar_samp_packer

Packs the 32-bit sc16 receive sample stream produced by the radar core's RX path into 512-bit AXI-stream words for the DDR3 sample buffer. It sits between the radar block's per-channel sample output and the memory-buffer write interface (SAMP_AXI_* widths). Each word carries 16 samples, and a frame boundary (`tlast`) flushes a partial word with a trimmed `tkeep`. One instance is used per channel, in the `ce_clk` domain.

## Interface
- `SAMP_AXI_DATA_WIDTH`, 512: output data width. Fixed at 512; any other value is a synthesis error.
- `SAMP_AXI_TID_WIDTH`, 1: `tid` width.
- `SAMP_AXI_TDEST_WIDTH`, 1: `tdest` width.
- `SAMP_AXI_TUSER_WIDTH`, 1: `tuser` width. Bit 0 is the start-of-frame flag.
- `TID_VALUE`, 0: constant driven on `tid`.
- `TDEST_VALUE`, 0: constant driven on `tdest`.

Ports (name, direction, width, meaning):
- `ce_clk` in 1: the single clock. All logic is on its rising edge.
- `ce_rst_n` in 1: reset, **asynchronous, active-low**. Asserts immediately; deassertion is sampled on `ce_clk`.
- `clear` in 1: synchronous abort. Discards the partially filled accumulator.
- `s_axis_tdata` in 32: sample, {I[31:16], Q[15:0]}.
- `s_axis_tlast` in 1: last sample of the frame.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `samp_axis_tdata` out 512: packed samples.
- `samp_axis_tvalid` out 1: output valid.
- `samp_axis_tlast` out 1: last word of the frame.
- `samp_axis_tkeep` out 64: byte enables.
- `samp_axis_tstrb` out 64: always equal to `tkeep`.
- `samp_axis_tid` out TID_W: equals `TID_VALUE`.
- `samp_axis_tdest` out TDEST_W: equals `TDEST_VALUE`.
- `samp_axis_tuser` out TUSER_W: bit 0 = first word of the frame; upper bits 0.
- `samp_axis_tready` in 1: downstream ready.
- `frame_cnt` out 32: number of frames emitted, counted on the output handshake when `tlast`=1. Wraps from 0xFFFFFFFF to 0.

## Operation
- **State**
  - accumulator `acc[511:0]`.
  - fill count `cnt[3:0]`, range 0..15.
  - start-of-frame flag `sof`, reset value 1.
  - one output holding register: data, keep, last, sof, valid.
- **Accept.** An input beat is accepted when `s_axis_tvalid && s_axis_tready`.
  - The sample is written to `acc[32*cnt+31 : 32*cnt]`. Sample 0 of a word is in bits [31:0].
- **Word completion.** A word completes when an accepted beat has `cnt==15` or `s_axis_tlast==1`. On completion:
  - The output register loads `acc` with the new sample merged in. Lanes above `cnt` are zeroed.
  - `tkeep` = 4·(cnt+1) low ones. A full word gives all ones.
  - `tlast` = `s_axis_tlast`.
  - `tuser[0]` = `sof`.
  - `valid` is set.
  - `cnt` and `acc` return to 0.
  - `sof` becomes `s_axis_tlast`, so the next word after a frame end is marked as the start of a frame.
- **Other accepted beats.** Any accepted beat that does not complete a word increments `cnt`.
- **Ready.** `s_axis_tready = ce_rst_n_q && (!samp_axis_tvalid || samp_axis_tready)`.
  - `ce_rst_n_q` is a register cleared by reset and set 1 cycle after reset deasserts.
  - The ready condition is applied on every beat, not only completing beats. This keeps the timing path short.
- **Output handshake.**
  - `samp_axis_tvalid` clears when `samp_axis_tready` is high and no new word completes in the same cycle.
  - If a word completes in the same cycle as the output drains, the register reloads back-to-back and `valid` stays 1.
- **`clear`**
  - Zeroes `acc` and `cnt`, and sets `sof`=1.
  - It does not affect a word already in the output register; that word drains normally.
  - A beat offered in the same cycle as `clear` is not accepted: `s_axis_tready` is forced 0 while `clear`=1.
- **`tlast` on a beat that also fills lane 15:** one full word with `tlast`=1. No empty word follows.
- **Zero-length frames cannot occur.** `tlast` always accompanies a sample.

## Timing
- **Reset values.**
  - `samp_axis_tvalid`/`tlast`/`tuser` = 0; `tdata`/`tkeep`/`tstrb` = 0.
  - `s_axis_tready` = 0.
  - `frame_cnt` = 0, `cnt` = 0, `sof` = 1.
- **Latency.** The completing beat is accepted in cycle N; `samp_axis_tvalid`=1 in cycle N+1.
- **Throughput.** 1 sample per cycle sustained while `samp_axis_tready`=1, giving one 512-bit word every 16 cycles.
- **Backpressure.** Once `samp_axis_tvalid` is asserted, it and all payload outputs hold stable until the handshake. Data is never dropped or duplicated.
- **Reset mid-frame.** All state is lost and the next accepted sample starts a new frame with `tuser`=1.

## Test plan
- **Full word.** Reset, then 16 beats with data 0x00000000..0x0000000F and `tlast` on the 16th, `samp_axis_tready`=1.
  - Expect one word, 1 cycle after the 16th beat: lane k = k, `tkeep`=all ones, `tlast`=1, `tuser`=1, `frame_cnt`=1.
- **Partial flush.** A 20-sample frame with data 0xA0000000+k.
  - Word 1: full, `tuser`=1, `tlast`=0.
  - Word 2: lanes 0–3 = 0xA0000010..0xA0000013, lanes 4–15 = 0, `tkeep`=0x0000_0000_0000_FFFF, `tlast`=1, `tuser`=0.
- **Backpressure.** `samp_axis_tready`=0 for 40 cycles during a 48-sample frame.
  - `s_axis_tready` drops after the first completed word.
  - The output payload stays stable throughout.
  - After release: 3 words in order, no loss.
- **Clear.** Issue `clear` after 7 samples, then send a 16-sample frame.
  - Exactly one word, containing only the post-clear samples, `tuser`=1.
- **Back-to-back drain.** `samp_axis_tready`=1 with continuous valid for 160 samples in a single frame.
  - 10 words with no bubble cycle on input.
  - `tlast` on word 10 only; `frame_cnt`=1.
- **Async reset.** Assert `ce_rst_n`=0 mid-cycle while a word is held.
  - Outputs go to their reset values without waiting for a clock edge.
  - `s_axis_tready` returns to 1 one cycle after deassertion.
